// File: rtl/conv_loop_controller.sv
// Loop/sequencing controller for the convolution datapath: walks x > y > ch_in > ch_out > ky > kx
// over paired operand handshakes, driving MAC control, partial-sum memory and a result stream.
module conv_loop_controller #(
  parameter int CNT_WIDTH       = 8,
  parameter int MAX_KERNEL_SIZE = 7,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_height,
  input  logic [CNT_WIDTH-1:0]  cfg_in_ch,
  input  logic [CNT_WIDTH-1:0]  cfg_out_ch,
  input  logic [CNT_WIDTH-1:0]  cfg_kernel,
  output logic                  running,
  output logic                  cfg_err,
  output logic                  done,
  input  logic                  a_valid,
  input  logic                  b_valid,
  output logic                  a_ready,
  output logic                  b_ready,
  output logic                  mac_valid,
  output logic                  mac_accumulate_internal,
  output logic                  mac_accumulate_with_0,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  out_x,
  output logic [CNT_WIDTH-1:0]  out_y,
  output logic [CNT_WIDTH-1:0]  out_ch,
  output logic [CNT_WIDTH-1:0]  cur_x,
  output logic [CNT_WIDTH-1:0]  cur_y,
  output logic [CNT_WIDTH-1:0]  cur_ch_in,
  output logic [CNT_WIDTH-1:0]  cur_ch_out,
  output logic [CNT_WIDTH-1:0]  cur_ky,
  output logic [CNT_WIDTH-1:0]  cur_kx,
  output logic [1:0]            state_dbg
);

  // Handshake: operands transfer only when a_valid & b_valid & a_ready (a_ready == b_ready);
  // a result transfers when out_valid & out_ready, and out_* hold stable while out_valid is pending.

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] w_q, h_q, ic_q, oc_q, k_q;
  logic [CNT_WIDTH-1:0] x_q, y_q, ci_q, co_q, ky_q, kx_q;

  logic cfg_ok, stall, fire;
  logic kx_last, ky_last, co_last, ci_last, y_last, x_last;
  logic first_tap, last_tap, last_all;

  assign cfg_ok = (cfg_width != '0) && (cfg_height != '0) && (cfg_in_ch != '0) &&
                  (cfg_out_ch != '0) && (cfg_kernel != '0) &&
                  (cfg_kernel <= CNT_WIDTH'(MAX_KERNEL_SIZE));

  assign kx_last   = (kx_q == k_q  - CNT_WIDTH'(1));
  assign ky_last   = (ky_q == k_q  - CNT_WIDTH'(1));
  assign co_last   = (co_q == oc_q - CNT_WIDTH'(1));
  assign ci_last   = (ci_q == ic_q - CNT_WIDTH'(1));
  assign y_last    = (y_q  == h_q  - CNT_WIDTH'(1));
  assign x_last    = (x_q  == w_q  - CNT_WIDTH'(1));
  assign first_tap = (kx_q == '0) && (ky_q == '0);
  assign last_tap  = kx_last && ky_last;
  assign last_all  = last_tap && co_last && ci_last && y_last && x_last;

  // State register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; abort outranks everything, including start
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && cfg_ok) state_d = RUN;
        RUN:     if (fire && last_all) state_d = DRAIN;
        DRAIN:   if (out_valid && out_ready) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    running                 = (state_q != IDLE);
    done                    = (state_q == DONE);
    stall                   = out_valid && !out_ready;
    a_ready                 = (state_q == RUN) && !stall;
    b_ready                 = a_ready;
    fire                    = a_valid && b_valid && a_ready;
    mac_valid               = fire;
    mac_accumulate_internal = (state_q == RUN) && !first_tap;
    mac_accumulate_with_0   = (state_q == RUN) && first_tap && (ci_q == '0);
    mem_re                  = fire && first_tap && (ci_q != '0);
    mem_read_addr           = ADDR_WIDTH'(co_q);
    state_dbg               = state_q;
  end

  // Datapath: config latches, loop counters, partial-sum write and result registers
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      w_q <= '0; h_q <= '0; ic_q <= '0; oc_q <= '0; k_q <= '0;
      x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; ky_q <= '0; kx_q <= '0;
      cfg_err        <= 1'b0;
      mem_we         <= 1'b0;
      mem_write_addr <= '0;
      out_valid      <= 1'b0;
      out_x          <= '0;
      out_y          <= '0;
      out_ch         <= '0;
    end else if (abort) begin
      x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; ky_q <= '0; kx_q <= '0;
      cfg_err   <= 1'b0;
      mem_we    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      mem_we  <= fire && last_tap && !ci_last;
      if (fire && last_tap && !ci_last) mem_write_addr <= ADDR_WIDTH'(co_q);

      if (state_q == IDLE && start) begin
        w_q  <= cfg_width;
        h_q  <= cfg_height;
        ic_q <= cfg_in_ch;
        oc_q <= cfg_out_ch;
        k_q  <= cfg_kernel;
        cfg_err <= !cfg_ok;
        x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; ky_q <= '0; kx_q <= '0;
      end

      if (fire) begin
        if (!kx_last) kx_q <= kx_q + CNT_WIDTH'(1);
        else begin
          kx_q <= '0;
          if (!ky_last) ky_q <= ky_q + CNT_WIDTH'(1);
          else begin
            ky_q <= '0;
            if (!co_last) co_q <= co_q + CNT_WIDTH'(1);
            else begin
              co_q <= '0;
              if (!ci_last) ci_q <= ci_q + CNT_WIDTH'(1);
              else begin
                ci_q <= '0;
                if (!y_last) y_q <= y_q + CNT_WIDTH'(1);
                else begin
                  y_q <= '0;
                  x_q <= x_last ? '0 : x_q + CNT_WIDTH'(1);
                end
              end
            end
          end
        end
      end

      // A new result can only land when the previous one is gone or leaving this cycle
      if (fire && last_tap && ci_last) begin
        out_valid <= 1'b1;
        out_x     <= x_q;
        out_y     <= y_q;
        out_ch    <= co_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign cur_x      = x_q;
  assign cur_y      = y_q;
  assign cur_ch_in  = ci_q;
  assign cur_ch_out = co_q;
  assign cur_ky     = ky_q;
  assign cur_kx     = kx_q;

endmodule

// File: tb/tb_conv_loop_controller.sv
// Self-checking bench for conv_loop_controller: nested-loop reference model, randomized handshakes.
module tb_conv_loop_controller;

  localparam int W  = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [W-1:0]  cfg_width = '0, cfg_height = '0, cfg_in_ch = '0, cfg_out_ch = '0, cfg_kernel = '0;
  logic          a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic          running, cfg_err, done, a_ready, b_ready, mac_valid;
  logic          mac_accumulate_internal, mac_accumulate_with_0, mem_re, mem_we, out_valid;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [W-1:0]  out_x, out_y, out_ch, cur_x, cur_y, cur_ch_in, cur_ch_out, cur_ky, cur_kx;
  logic [1:0]    state_dbg;

  conv_loop_controller #(.CNT_WIDTH(W), .MAX_KERNEL_SIZE(7), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_in_ch(cfg_in_ch),
    .cfg_out_ch(cfg_out_ch), .cfg_kernel(cfg_kernel),
    .running(running), .cfg_err(cfg_err), .done(done),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .mac_valid(mac_valid), .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .mem_re(mem_re), .mem_read_addr(mem_read_addr), .mem_we(mem_we), .mem_write_addr(mem_write_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .cur_x(cur_x), .cur_y(cur_y), .cur_ch_in(cur_ch_in), .cur_ch_out(cur_ch_out),
    .cur_ky(cur_ky), .cur_kx(cur_kx), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int x, y, ci, co, ky, kx;
    bit acc_int, acc0, re, we, outp;
  } fire_t;

  fire_t          fire_q[$];
  logic [3*W-1:0] exp_q[$];
  bit             in_run, exp_ov, exp_we, exp_done, exp_cfg_err, done_seen;
  logic [AW-1:0]  exp_wa;
  int             fire_cnt, exp_fires;

  // Expected job: every operand pair in loop order, with what the controller must do on it
  task automatic build_job(input int w, input int h, input int ic, input int oc, input int k);
    fire_q.delete();
    exp_q.delete();
    for (int x = 0; x < w; x++)
      for (int y = 0; y < h; y++)
        for (int ci = 0; ci < ic; ci++)
          for (int co = 0; co < oc; co++)
            for (int ky = 0; ky < k; ky++)
              for (int kx = 0; kx < k; kx++) begin
                fire_t r;
                bit first, last;
                first = (kx == 0) && (ky == 0);
                last  = (kx == k - 1) && (ky == k - 1);
                r.x = x; r.y = y; r.ci = ci; r.co = co; r.ky = ky; r.kx = kx;
                r.acc_int = !first;
                r.acc0    = first && (ci == 0);
                r.re      = first && (ci != 0);
                r.we      = last && (ci != ic - 1);
                r.outp    = last && (ci == ic - 1);
                fire_q.push_back(r);
                if (r.outp) exp_q.push_back({W'(x), W'(y), W'(co)});
              end
    exp_fires = fire_q.size();
  endtask

  task automatic clear_model();
    fire_q.delete();
    exp_q.delete();
    in_run   = 1'b0;
    exp_ov   = 1'b0;
    exp_we   = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic monitor_step();
    bit    stall_m, exp_fire, hs, new_we, new_ov;
    fire_t r;
    stall_m = exp_ov && !out_ready;
    check_eq("a_ready", a_ready, in_run && !stall_m);
    check_eq("b_ready", b_ready, in_run && !stall_m);
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("done", done, exp_done);
    if (done) done_seen = 1'b1;
    check_eq("cfg_err", cfg_err, exp_cfg_err);
    exp_cfg_err = 1'b0;
    check_eq("mem_we", mem_we, exp_we);
    if (exp_we) check_eq("mem_write_addr", mem_write_addr, exp_wa);
    exp_fire = in_run && !stall_m && a_valid && b_valid;
    check_eq("mac_valid", mac_valid, exp_fire);

    hs = exp_ov && out_ready;
    if (exp_ov) begin
      if (exp_q.size() == 0) check_eq("out_extra", 1'b1, 1'b0);
      else begin
        check_eq("out_coord", {out_x, out_y, out_ch}, exp_q[0]);
        if (hs) void'(exp_q.pop_front());
      end
    end

    new_we = 1'b0;
    new_ov = 1'b0;
    if (exp_fire) begin
      if (fire_q.size() == 0) check_eq("fire_extra", 1'b1, 1'b0);
      else begin
        r = fire_q.pop_front();
        fire_cnt++;
        check_eq("counters", {cur_x, cur_y, cur_ch_in, cur_ch_out, cur_ky, cur_kx},
                 {W'(r.x), W'(r.y), W'(r.ci), W'(r.co), W'(r.ky), W'(r.kx)});
        check_eq("acc_internal", mac_accumulate_internal, r.acc_int);
        check_eq("acc_with_0", mac_accumulate_with_0, r.acc0);
        check_eq("mem_re", mem_re, r.re);
        if (r.re) check_eq("mem_read_addr", mem_read_addr, AW'(r.co));
        new_we = r.we;
        exp_wa = AW'(r.co);
        new_ov = r.outp;
        if (fire_q.size() == 0) in_run = 1'b0;
      end
    end else begin
      check_eq("mem_re_idle", mem_re, 1'b0);
    end

    exp_we   = new_we;
    exp_done = hs && (exp_q.size() == 0) && (fire_q.size() == 0) && !in_run;
    if (new_ov) exp_ov = 1'b1;
    else if (hs) exp_ov = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  // ---------------- driver ----------------
  int a_pct = 100, b_pct = 100, r_pct = 100;
  bit b_toggle = 1'b0, stall_first = 1'b0, stall_used = 1'b0;
  int hold_left = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (b_toggle) begin
      a_valid = 1'b1;
      b_valid = !b_valid;
    end else begin
      a_valid = ($urandom_range(0, 99) < a_pct);
      b_valid = ($urandom_range(0, 99) < b_pct);
    end
    if (stall_first && !stall_used && out_valid) begin
      stall_used = 1'b1;
      hold_left  = 5;
    end
    if (hold_left > 0) begin
      out_ready = 1'b0;
      hold_left--;
    end else begin
      out_ready = ($urandom_range(0, 99) < r_pct);
    end
  end

  task automatic start_job(input int w, input int h, input int ic, input int oc, input int k);
    bit ok;
    ok = (w > 0) && (h > 0) && (ic > 0) && (oc > 0) && (k > 0) && (k <= 7);
    @(posedge clk);
    #1;
    cfg_width = W'(w); cfg_height = W'(h); cfg_in_ch = W'(ic); cfg_out_ch = W'(oc); cfg_kernel = W'(k);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ok) begin
      build_job(w, h, ic, oc, k);
      in_run    = 1'b1;
      fire_cnt  = 0;
      done_seen = 1'b0;
    end else begin
      exp_cfg_err = 1'b1;
    end
    check_eq("running_after_start", running, ok);
  endtask

  // Waits for done; optionally pulses start with a different config mid-job (must be ignored)
  task automatic wait_job(input int poke_at);
    int n;
    n = 0;
    while (!done_seen && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
      if (n == poke_at) begin
        start = 1'b1;
        cfg_kernel = W'(2);
        cfg_width  = W'(5);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("job_done_seen", done_seen, 1'b1);
    check_eq("fires_left", fire_q.size(), 0);
    check_eq("outputs_left", exp_q.size(), 0);
    check_eq("fire_count", fire_cnt, exp_fires);
    @(posedge clk);
    #1;
    check_eq("running_after_done", running, 1'b0);
  endtask

  task automatic abort_after(input int n);
    repeat (n) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    clear_model();
    check_eq("abort_running", running, 1'b0);
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_mem_we", mem_we, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_idle", running, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_running", running, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_a_ready", a_ready, 1'b0);
    check_eq("rst_counters", {cur_x, cur_y, cur_ch_in, cur_ch_out, cur_ky, cur_kx}, 48'h0);
    check_eq("rst_state", state_dbg, 2'd0);
    arst_n_in = 1'b1;

    // 2x2 feature map, 1x1 kernel, free-flowing
    start_job(2, 2, 1, 1, 1);
    wait_job(0);

    // 1x1 map, 2 in / 2 out channels, 3x3 kernel, with a start pulse mid-job
    start_job(1, 1, 2, 2, 3);
    wait_job(12);

    // Output backpressure for 5 cycles on the first result
    stall_first = 1'b1;
    stall_used  = 1'b0;
    start_job(2, 2, 1, 1, 1);
    wait_job(0);
    stall_first = 1'b0;

    // Rejected configurations
    start_job(2, 2, 1, 1, 8);
    repeat (2) @(posedge clk);
    start_job(2, 2, 0, 1, 3);
    repeat (2) @(posedge clk);
    start_job(0, 2, 1, 1, 3);
    repeat (2) @(posedge clk);
    #1;
    check_eq("cfg_err_idle", running, 1'b0);

    // Abort mid-job, then a clean rerun
    start_job(1, 1, 2, 2, 3);
    abort_after(10);
    start_job(1, 1, 2, 2, 3);
    wait_job(0);

    // b_valid toggling every cycle with a_valid held high
    b_toggle = 1'b1;
    start_job(1, 1, 2, 2, 3);
    wait_job(0);
    b_toggle = 1'b0;

    // Randomized configurations and handshake rates
    for (int j = 0; j < 6; j++) begin
      a_pct = $urandom_range(50, 100);
      b_pct = $urandom_range(50, 100);
      r_pct = $urandom_range(40, 100);
      start_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(1, 3));
      wait_job(0);
    end

    // Asynchronous reset in the middle of a job
    a_pct = 100; b_pct = 100; r_pct = 100;
    start_job(2, 2, 2, 2, 2);
    repeat (20) @(posedge clk);
    #3;
    arst_n_in = 1'b0;
    #1;
    clear_model();
    check_eq("midrst_running", running, 1'b0);
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_counters", {cur_x, cur_y, cur_ch_in, cur_ch_out, cur_ky, cur_kx}, 48'h0);
    @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    start_job(2, 1, 1, 2, 2);
    wait_job(0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
